// File: rtl/shader_pkg.sv
// Shared types for the direct-lighting shader merge stage.
// Holds the blend-manager payload, channel index type and miss colour.
package shader_pkg;

  typedef struct packed {
    logic [15:0] pix;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } calc_direct_to_BM_t;

  localparam int CDM_CH_W = 2;

  typedef logic [CDM_CH_W-1:0] cdm_ch_t;

  localparam calc_direct_to_BM_t MISS_COLOR = '{
    pix: 16'h0000,
    r:   8'h20,
    g:   8'h28,
    b:   8'h40
  };

endpackage

// File: rtl/cdm_credit_fifo.sv
// One merge channel: issue credits, LAT-deep in-flight tracker, result FIFO.
// Ports: clk/rst (sync, active-low), issue_valid/issue_stall, res_valid/res_data,
// pop (arbiter grant), empty/head (FIFO head, combinational), err (sticky).
module cdm_credit_fifo
  import shader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LAT   = 4,
  parameter int W     = $bits(calc_direct_to_BM_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  output logic         issue_stall,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]  r_credit;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [LAT-1:0] r_fly;
  logic           r_err;
  logic [W-1:0]   r_mem [DEPTH];

  logic w_accept;
  logic w_expect;
  logic w_wr;
  logic w_pop;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stall is forced during reset so nothing is accepted
  // against stale credit state.
  assign issue_stall = ~rst | (r_credit == '0);
  assign w_accept    = issue_valid & ~issue_stall;
  assign w_expect    = r_fly[LAT-1];
  assign w_wr        = res_valid & w_expect;
  assign empty       = (r_count == '0);
  assign w_pop       = pop & ~empty;
  assign head        = r_mem[r_rptr];
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_credit <= CW'(DEPTH);
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fly    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_credit <= r_credit + CW'(w_pop) - CW'(w_accept);
      r_count  <= r_count + CW'(w_wr) - CW'(w_pop);
      r_fly    <= (r_fly << 1) | LAT'(w_accept);
      if (res_valid != w_expect) r_err <= 1'b1;
      if (w_wr)  r_wptr <= f_inc(r_wptr);
      if (w_pop) r_rptr <= f_inc(r_rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= res_data;
  end

endmodule

// File: rtl/calc_direct_merge.sv
// Direct-lighting merge: NUM_CH credit-admitted channels drained round-robin.
// Ports: clk/rst (sync, active-low), issue_valid/issue_stall[NUM_CH],
// res_valid[NUM_CH], res_data[NUM_CH*W] (ch0 in LSBs), ds_valid/ds_stall,
// ds_data[W], ds_ch, err (sticky). Define CALC_DIRECT_MERGE_STATS_EN to add
// stat_grants[NUM_CH*32] (pops per channel) and stat_stall_cycles[32].
module calc_direct_merge
  import shader_pkg::*;
#(
  parameter int  NUM_CH = 3,
  parameter int  DEPTH  = 16,
  parameter int  LAT    = 4,
  parameter int  W      = $bits(calc_direct_to_BM_t),
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   issue_valid,
  output logic [NUM_CH-1:0]   issue_stall,
  input  logic [NUM_CH-1:0]   res_valid,
  input  logic [NUM_CH*W-1:0] res_data,
  output logic                ds_valid,
  input  logic                ds_stall,
  output logic [W-1:0]        ds_data,
  output logic [CHW-1:0]      ds_ch,
  output logic                err
`ifdef CALC_DIRECT_MERGE_STATS_EN
  ,
  output logic [NUM_CH*32-1:0] stat_grants,
  output logic [31:0]          stat_stall_cycles
`endif
);

  logic [NUM_CH-1:0]        w_empty;
  logic [NUM_CH-1:0]        w_err;
  logic [NUM_CH-1:0]        w_pop;
  logic [NUM_CH-1:0][W-1:0] w_head;
  logic [CHW-1:0]           w_srch;
  logic [CHW-1:0]           w_grant;
  logic [CHW-1:0]           w_rr_nxt;
  logic                     w_pop_any;

  logic [CHW-1:0] r_rr;
  logic           r_lock;
  logic [CHW-1:0] r_lock_ch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cdm_credit_fifo #(
      .DEPTH (DEPTH),
      .LAT   (LAT),
      .W     (W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid[g]),
      .issue_stall (issue_stall[g]),
      .res_valid   (res_valid[g]),
      .res_data    (res_data[g*W +: W]),
      .pop         (w_pop[g]),
      .empty       (w_empty[g]),
      .head        (w_head[g]),
      .err         (w_err[g])
    );
  end

  // First non-empty channel at or after r_rr, wrapping.
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    w_srch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && !w_empty[idx]) begin
        found  = 1'b1;
        w_srch = CHW'(idx);
      end
    end
  end

  // A stalled grant is held so ds_* stay stable until it pops.
  assign w_grant   = r_lock ? r_lock_ch : w_srch;
  assign ds_valid  = rst & ~(&w_empty);
  assign ds_data   = w_head[w_grant];
  assign ds_ch     = w_grant;
  assign err       = |w_err;
  assign w_pop_any = ds_valid & ~ds_stall;
  assign w_rr_nxt  = (w_grant == CHW'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop[i] = w_pop_any && (w_grant == CHW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr      <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_pop_any) begin
      r_rr   <= w_rr_nxt;
      r_lock <= 1'b0;
    end else if (ds_valid) begin
      r_lock    <= 1'b1;
      r_lock_ch <= w_grant;
    end
  end

`ifdef CALC_DIRECT_MERGE_STATS_EN
  logic [NUM_CH-1:0][31:0] r_grants;
  logic [31:0]             r_stall_cyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grants    <= '0;
      r_stall_cyc <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_pop[i]) r_grants[i] <= r_grants[i] + 32'd1;
      end
      if (ds_valid && ds_stall) r_stall_cyc <= r_stall_cyc + 32'd1;
    end
  end

  assign stat_grants       = r_grants;
  assign stat_stall_cycles = r_stall_cyc;
`endif

endmodule
